// File: rtl/gn_mdl_axis_pkg.sv
// Shared types and helpers for the gn_mdl AXI4-Stream model blocks.
package gn_mdl_axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } axis_arb_state_t;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int f_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gn_mdl_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from last+1.
module gn_mdl_rr_pick
  import gn_mdl_axis_pkg::*;
#(
  parameter int P_NUM_SRC = 4,
  parameter int SW        = f_clog2_min1(P_NUM_SRC)
) (
  input  logic [P_NUM_SRC-1:0] req,
  input  logic [SW-1:0]        last,
  output logic                 found,
  output logic [SW-1:0]        idx
);

  logic [SW-1:0] cand;

  // Offsets 1..N so that the source after last wins and last itself is checked last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= P_NUM_SRC; i++) begin
      cand = SW'((int'(last) + i) % P_NUM_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gn_mdl_axis_rr_arb.sv
// Round-robin AXI4-Stream arbiter merging P_NUM_SRC masters into one sink,
// holding each grant for up to P_MAX_BURST beats or until the source drops valid.
module gn_mdl_axis_rr_arb
  import gn_mdl_axis_pkg::*;
#(
  parameter int P_DWIDTH    = 32,
  parameter int P_NUM_SRC   = 4,
  parameter int P_MAX_BURST = 16,
  parameter int SW          = f_clog2_min1(P_NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [P_NUM_SRC*P_DWIDTH-1:0] s_axis_tdata,
  input  logic [P_NUM_SRC-1:0]          s_axis_tvalid,
  output logic [P_NUM_SRC-1:0]          s_axis_tready,
  output logic [P_DWIDTH-1:0]           m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [SW-1:0]                 m_axis_tdest,
  output logic                          o_busy
);

  localparam int CW = f_clog2_min1(P_MAX_BURST + 1);

  axis_arb_state_t state, state_nxt;
  logic [SW-1:0]   grant, grant_nxt;
  logic [SW-1:0]   last, last_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            pick_found;
  logic [SW-1:0]   pick_idx;
  logic            handshake;
  logic [P_DWIDTH-1:0] src_data [P_NUM_SRC];

  for (genvar g = 0; g < P_NUM_SRC; g++) begin : g_src
    assign src_data[g] = s_axis_tdata[g*P_DWIDTH +: P_DWIDTH];
  end

  gn_mdl_rr_pick #(
    .P_NUM_SRC(P_NUM_SRC),
    .SW       (SW)
  ) u_pick (
    .req  (s_axis_tvalid),
    .last (last),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= SW'(P_NUM_SRC - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    last_nxt      = last;
    beat_cnt_nxt  = beat_cnt;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tdest  = '0;
    s_axis_tready = '0;
    o_busy        = 1'b0;
    handshake     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        o_busy               = 1'b1;
        m_axis_tvalid        = s_axis_tvalid[grant];
        m_axis_tdata         = src_data[grant];
        m_axis_tdest         = grant;
        s_axis_tready[grant] = m_axis_tready;
        handshake            = s_axis_tvalid[grant] && m_axis_tready;
        if (handshake) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end
        if ((handshake && beat_cnt == CW'(P_MAX_BURST - 1)) || !s_axis_tvalid[grant]) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset blanks the outputs immediately so an in-flight beat cannot complete.
    if (reset) begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tdest  = '0;
      s_axis_tready = '0;
      o_busy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_gn_mdl_axis_rr_arb.sv
// Directed bench for gn_mdl_axis_rr_arb; three instances share stimulus and differ in burst limit.
module tb_gn_mdl_axis_rr_arb;

  localparam int DW = 32;
  localparam int NS = 4;

  logic            clk      = 1'b0;
  logic            reset    = 1'b1;
  logic [NS*DW-1:0] s_tdata = '0;
  logic [NS-1:0]   s_tvalid = '0;
  logic            m_tready = 1'b0;

  logic [NS-1:0] a_tready, b_tready, c_tready;
  logic [DW-1:0] a_tdata, b_tdata, c_tdata;
  logic          a_tvalid, b_tvalid, c_tvalid;
  logic [1:0]    a_tdest, b_tdest, c_tdest;
  logic          a_busy, b_busy, c_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gn_mdl_axis_rr_arb #(.P_DWIDTH(DW), .P_NUM_SRC(NS), .P_MAX_BURST(16)) dut_a (
    .clk(clk), .reset(reset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(a_tready), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdest(a_tdest), .o_busy(a_busy));

  gn_mdl_axis_rr_arb #(.P_DWIDTH(DW), .P_NUM_SRC(NS), .P_MAX_BURST(4)) dut_b (
    .clk(clk), .reset(reset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(b_tready), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdest(b_tdest), .o_busy(b_busy));

  gn_mdl_axis_rr_arb #(.P_DWIDTH(DW), .P_NUM_SRC(NS), .P_MAX_BURST(2)) dut_c (
    .clk(clk), .reset(reset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(c_tready), .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid),
    .m_axis_tready(m_tready), .m_axis_tdest(c_tdest), .o_busy(c_busy));

  function automatic logic [NS*DW-1:0] pack(input logic [31:0] d0, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Drive one cycle's inputs after the falling edge, then settle before checks.
  task automatic apply_stimulus(input logic r, input logic [NS-1:0] v, input logic rdy,
                                input logic [NS*DW-1:0] d);
    @(negedge clk);
    reset    = r;
    s_tvalid = v;
    m_tready = rdy;
    s_tdata  = d;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int beat;
    logic rdy;
    logic idle_c;
    int src;

    // Reset, then a single 5-beat packet from source 2 on the 16-beat instance.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 4'h0, 1'b1, '0);
      check_output("rst_tvalid", a_tvalid, 0);
      check_output("rst_tdata", a_tdata, 0);
      check_output("rst_tdest", a_tdest, 0);
      check_output("rst_tready", a_tready, 0);
      check_output("rst_busy", a_busy, 0);
    end
    apply_stimulus(1'b0, 4'b0100, 1'b1, pack(0, 0, 32'hA0, 0));
    check_output("t1_idle_tvalid", a_tvalid, 0);
    check_output("t1_idle_busy", a_busy, 0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 4'b0100, 1'b1, pack(0, 0, 32'hA0 + k, 0));
      check_output("t1_tvalid", a_tvalid, 1);
      check_output("t1_tdata", a_tdata, 32'hA0 + k);
      check_output("t1_tdest", a_tdest, 2);
      check_output("t1_tready", a_tready, 4'b0100);
      check_output("t1_busy", a_busy, 1);
    end
    apply_stimulus(1'b0, 4'h0, 1'b1, '0);
    check_output("t1_rel_tvalid", a_tvalid, 0);
    check_output("t1_rel_busy", a_busy, 1);
    apply_stimulus(1'b0, 4'h0, 1'b1, '0);
    check_output("t1_after_busy", a_busy, 0);

    // Burst limit 4: ten beats from source 0 arrive as 4,4,2 with a bubble before each grant.
    apply_stimulus(1'b1, 4'h0, 1'b1, '0);
    beat = 0;
    for (int c = 0; c < 15; c++) begin
      idle_c = (c == 0) || (c == 5) || (c == 10) || (c == 14);
      apply_stimulus(1'b0, (beat < 10) ? 4'b0001 : 4'b0000, 1'b1, pack(32'hB0 + beat, 0, 0, 0));
      check_output("t2_busy", b_busy, {31'd0, !idle_c});
      check_output("t2_tvalid", b_tvalid, {31'd0, !idle_c && beat < 10});
      if (!idle_c && beat < 10) begin
        check_output("t2_tdata", b_tdata, 32'hB0 + beat);
        beat++;
      end
    end

    // Fairness with burst limit 2: grants rotate 0,1,2,3,0 with two beats each.
    apply_stimulus(1'b1, 4'h0, 1'b1, '0);
    for (int c = 0; c < 15; c++) begin
      apply_stimulus(1'b0, 4'hF, 1'b1, pack(32'hC0, 32'hC1, 32'hC2, 32'hC3));
      if (c % 3 == 0) begin
        check_output("t3_bubble_tvalid", c_tvalid, 0);
        check_output("t3_bubble_busy", c_busy, 0);
      end else begin
        src = (c / 3) % 4;
        check_output("t3_tvalid", c_tvalid, 1);
        check_output("t3_tdest", c_tdest, src);
        check_output("t3_tdata", c_tdata, 32'hC0 + src);
        check_output("t3_tready", c_tready, 32'd1 << src);
      end
    end

    // Backpressure: sink stalls 7 cycles during a 6-beat packet from source 1.
    apply_stimulus(1'b1, 4'h0, 1'b1, '0);
    beat = 0;
    for (int c = 0; c < 14; c++) begin
      rdy = !(c >= 3 && c <= 9);
      apply_stimulus(1'b0, 4'b0010, rdy, pack(0, 32'hD0 + beat, 0, 0));
      if (c == 0) begin
        check_output("t4_idle_tvalid", a_tvalid, 0);
      end else begin
        check_output("t4_tvalid", a_tvalid, 1);
        check_output("t4_tdata", a_tdata, 32'hD0 + beat);
        check_output("t4_tdest", a_tdest, 1);
        check_output("t4_tready", a_tready, rdy ? 4'b0010 : 4'b0000);
        if (rdy) beat++;
      end
    end
    apply_stimulus(1'b0, 4'h0, 1'b1, '0);
    check_output("t4_rel_tvalid", a_tvalid, 0);
    check_output("t4_rel_busy", a_busy, 1);

    // Mid-burst reset during a packet from source 3, then source 0 wins against 3.
    apply_stimulus(1'b1, 4'h0, 1'b1, '0);
    apply_stimulus(1'b0, 4'b1000, 1'b1, pack(0, 0, 0, 32'hE0));
    check_output("t5_idle_tvalid", a_tvalid, 0);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b0, 4'b1000, 1'b1, pack(0, 0, 0, 32'hE0 + k));
      check_output("t5_tdest", a_tdest, 3);
      check_output("t5_tdata", a_tdata, 32'hE0 + k);
    end
    apply_stimulus(1'b1, 4'b1000, 1'b1, pack(0, 0, 0, 32'hE2));
    check_output("t5_rst_tvalid", a_tvalid, 0);
    check_output("t5_rst_tready", a_tready, 0);
    check_output("t5_rst_busy", a_busy, 0);
    apply_stimulus(1'b0, 4'b1001, 1'b1, pack(32'hF0, 0, 0, 32'hE2));
    check_output("t5_post_tvalid", a_tvalid, 0);
    check_output("t5_post_busy", a_busy, 0);
    apply_stimulus(1'b0, 4'b1001, 1'b1, pack(32'hF0, 0, 0, 32'hE2));
    check_output("t5_grant_tvalid", a_tvalid, 1);
    check_output("t5_grant_tdest", a_tdest, 0);
    check_output("t5_grant_tdata", a_tdata, 32'hF0);
    check_output("t5_grant_tready", a_tready, 4'b0001);

    // Valid drop: source 1 stops after 3 beats, waiting source 2 follows after one idle cycle.
    apply_stimulus(1'b1, 4'h0, 1'b1, '0);
    apply_stimulus(1'b0, 4'b0110, 1'b1, pack(0, 32'h60, 32'h70, 0));
    check_output("t6_idle_tvalid", a_tvalid, 0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 4'b0110, 1'b1, pack(0, 32'h60 + k, 32'h70, 0));
      check_output("t6_tdest", a_tdest, 1);
      check_output("t6_tdata", a_tdata, 32'h60 + k);
      check_output("t6_tready", a_tready, 4'b0010);
    end
    apply_stimulus(1'b0, 4'b0100, 1'b1, pack(0, 0, 32'h70, 0));
    check_output("t6_drop_tvalid", a_tvalid, 0);
    check_output("t6_drop_busy", a_busy, 1);
    apply_stimulus(1'b0, 4'b0100, 1'b1, pack(0, 0, 32'h70, 0));
    check_output("t6_gap_tvalid", a_tvalid, 0);
    check_output("t6_gap_busy", a_busy, 0);
    apply_stimulus(1'b0, 4'b0100, 1'b1, pack(0, 0, 32'h70, 0));
    check_output("t6_next_tvalid", a_tvalid, 1);
    check_output("t6_next_tdest", a_tdest, 2);
    check_output("t6_next_tdata", a_tdata, 32'h70);
    check_output("t6_next_tready", a_tready, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
